multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 71 +++++++
 rtl/multicycle_controller_alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
// Holds: FSM state enum, opcode constants, immsrc / alucontrol encodings,
//        datapath mux-select constants and the aluop codes fed to alu_decoder.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_HALT     = 4'd14
   } state_t;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Immediate extender selects
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU operations
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   // ALU source A / source B / result mux selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;
   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // Coarse ALU request from the FSM; FUNCT defers to funct3/funct7b5
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Purpose: map FSM aluop + funct3/funct7b5/op[5] to a 4-bit alucontrol.
// Latency: purely combinational. Backpressure: none.
// Ports: aluop[1:0], funct3[2:0], funct7b5, op5 in; alucontrol[3:0] out.
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [3:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (op5=1) distinguishes add/sub; addi with
               // imm[10] set must still add.
               3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alucontrol = ALU_SLL;
               3'b010:  alucontrol = ALU_SLT;
               3'b011:  alucontrol = ALU_SLTU;
               3'b100:  alucontrol = ALU_XOR;
               // srl/sra and srli/srai both key off funct7b5
               3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alucontrol = ALU_OR;
               default: alucontrol = ALU_AND;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle RV32I control FSM driving datapath strobes and mux selects.
// Latency: R/I/U/J/jalr 4, lw 5, sw 4, branch 3 cycles at zero wait states.
// Backpressure: mem_req held in FETCH/MEMREAD/MEMWRITE until mem_ready.
// Ports: clk, resetn (async, active-low); op, funct3, funct7b5, zero, mem_ready in;
//        mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
//        alusrca, alusrcb, immsrc, alucontrol, illegal (sticky) out.
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] immsrc,
   output logic [3:0] alucontrol,
   output logic       illegal
);

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [1:0] aluop;

   // Raw strobes before reset gating
   logic mem_req_c, pcwrite_c, memwrite_c, irwrite_c, regwrite_c;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Set on entry so the flag is already high in the first HALT cycle
   assign illegal_d = illegal_q | (state_d == S_HALT);

   always_comb begin
      state_d    = state_q;
      mem_req_c  = 1'b0;
      pcwrite_c  = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      adrsrc     = 1'b0;
      resultsrc  = RES_ALUOUT;
      alusrca    = SRCA_PC;
      alusrcb    = SRCB_RD2;
      immsrc     = IMM_I;
      aluop      = ALUOP_ADD;

      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALURES;
            irwrite_c = mem_ready;
            pcwrite_c = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Precompute branch target into the ALU output register
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
            immsrc  = IMM_B;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            alusrca = SRCA_RD1;
            alusrcb = SRCB_IMM;
            immsrc  = (op == OP_LOAD) ? IMM_I : IMM_S;
            state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req_c = 1'b1;
            adrsrc    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc  = RES_DATA;
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_c  = 1'b1;
            adrsrc     = 1'b1;
            memwrite_c = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            alusrca = SRCA_RD1;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            alusrca = SRCA_RD1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca = SRCA_RD1;
            aluop   = ALUOP_SUB;
            case (funct3)
               3'b000:  pcwrite_c = zero;
               3'b001:  pcwrite_c = ~zero;
               default: pcwrite_c = 1'b0;
            endcase
            state_d = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target from DECODE; ALU forms oldpc+4 for rd
            alusrca   = SRCA_OLDPC;
            alusrcb   = SRCB_FOUR;
            immsrc    = IMM_J;
            pcwrite_c = 1'b1;
            state_d   = S_ALUWB;
         end
         S_JALR: begin
            alusrca   = SRCA_RD1;
            alusrcb   = SRCB_IMM;
            resultsrc = RES_ALURES;
            pcwrite_c = 1'b1;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            alusrca = SRCA_ZERO;
            alusrcb = SRCB_IMM;
            immsrc  = IMM_U;
            state_d = S_ALUWB;
         end
         S_AUIPC: begin
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
            immsrc  = IMM_U;
            state_d = S_ALUWB;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .alucontrol (alucontrol)
   );

   // The state register sits in FETCH during reset, so strobes are
   // masked directly by resetn to keep memory and regfile quiet.
   assign mem_req  = mem_req_c  & resetn;
   assign pcwrite  = pcwrite_c  & resetn;
   assign memwrite = memwrite_c & resetn;
   assign irwrite  = irwrite_c  & resetn;
   assign regwrite = regwrite_c & resetn;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   logic       clk;
   logic       resetn;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
   logic [1:0] resultsrc, alusrca, alusrcb;
   logic [2:0] immsrc;
   logic [3:0] alucontrol;

   multicycle_controller dut (
      .clk        (clk),
      .resetn     (resetn),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .pcwrite    (pcwrite),
      .adrsrc     (adrsrc),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .resultsrc  (resultsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .immsrc     (immsrc),
      .alucontrol (alucontrol),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] v;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // {mem_req,pcwrite,adrsrc,memwrite,irwrite,regwrite,illegal,
   //  resultsrc,alusrca,alusrcb,immsrc,alucontrol}
   function automatic logic [19:0] mk(input logic mr, input logic pw, input logic ad,
                                      input logic mw, input logic iw, input logic rw,
                                      input logic il, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] im, input logic [3:0] ac);
      return {mr, pw, ad, mw, iw, rw, il, rs, sa, sb, im, ac};
   endfunction

   // Monitor: one observation per cycle, compared against the oldest expectation
   always @(negedge clk) begin
      logic [19:0] got;
      exp_t        e;
      cyc = cyc + 1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal,
                resultsrc, alusrca, alusrcb, immsrc, alucontrol};
         total = total + 1;
         if (got !== e.v) begin
            bad = bad + 1;
            $display("FAIL %s (cycle %0d): got=%05h expected=%05h", e.nm, cyc, got, e.v);
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected for that cycle
   task automatic st(input logic rn, input logic [31:0] ins, input logic z,
                     input logic mr, input logic [19:0] e, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      resetn    = rn;
      op        = ins[6:0];
      funct3    = ins[14:12];
      funct7b5  = ins[30];
      zero      = z;
      mem_ready = mr;
      x.v  = e;
      x.nm = nm;
      exp_q.push_back(x);
   endtask

   logic [19:0] RST, F1, FW, DEC, AWB, EXR_ADD, EXR_SUB, EXI_SRAI, EXI_ADDI;
   logic [19:0] MA_LW, MA_SW, MRD, MWB, MWR, BR_T, BR_N, JALV, JALRV, LUIV, AUIV, HLT;

   initial begin
      RST      = mk(0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,3'b000,4'b0000);
      F1       = mk(1,1,0,0,1,0,0, 2'b10,2'b00,2'b10,3'b000,4'b0000);
      FW       = mk(1,0,0,0,0,0,0, 2'b10,2'b00,2'b10,3'b000,4'b0000);
      DEC      = mk(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,3'b010,4'b0000);
      AWB      = mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,3'b000,4'b0000);
      EXR_ADD  = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,3'b000,4'b0000);
      EXR_SUB  = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,3'b000,4'b0001);
      EXI_SRAI = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000,4'b1000);
      EXI_ADDI = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000,4'b0000);
      MA_LW    = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000,4'b0000);
      MA_SW    = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,3'b001,4'b0000);
      MRD      = mk(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,3'b000,4'b0000);
      MWB      = mk(0,0,0,0,0,1,0, 2'b01,2'b00,2'b00,3'b000,4'b0000);
      MWR      = mk(1,0,1,1,0,0,0, 2'b00,2'b00,2'b00,3'b000,4'b0000);
      BR_T     = mk(0,1,0,0,0,0,0, 2'b00,2'b10,2'b00,3'b000,4'b0001);
      BR_N     = mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,3'b000,4'b0001);
      JALV     = mk(0,1,0,0,0,0,0, 2'b00,2'b01,2'b10,3'b011,4'b0000);
      JALRV    = mk(0,1,0,0,0,0,0, 2'b10,2'b10,2'b01,3'b000,4'b0000);
      LUIV     = mk(0,0,0,0,0,0,0, 2'b00,2'b11,2'b01,3'b100,4'b0000);
      AUIV     = mk(0,0,0,0,0,0,0, 2'b00,2'b01,2'b01,3'b100,4'b0000);
      HLT      = mk(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,3'b000,4'b0000);

      resetn = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      zero = 1'b0; mem_ready = 1'b1;

      // Reset with mem_ready high: strobes stay low
      st(0, 32'h002081B3, 0, 1, RST, "reset_quiet");
      st(0, 32'h002081B3, 0, 1, RST, "reset_quiet2");

      // add x3,x1,x2
      st(1, 32'h002081B3, 0, 1, F1,      "add_fetch");
      st(1, 32'h002081B3, 0, 1, DEC,     "add_decode");
      st(1, 32'h002081B3, 0, 1, EXR_ADD, "add_execr");
      st(1, 32'h002081B3, 0, 1, AWB,     "add_aluwb");

      // sub x4,x1,x2 with one fetch wait state
      st(1, 32'h40208233, 0, 0, FW,      "sub_fetch_wait");
      st(1, 32'h40208233, 0, 1, F1,      "sub_fetch");
      st(1, 32'h40208233, 0, 1, DEC,     "sub_decode");
      st(1, 32'h40208233, 0, 1, EXR_SUB, "sub_execr");
      st(1, 32'h40208233, 0, 1, AWB,     "sub_aluwb");

      // srai x1,x1,1
      st(1, 32'h4010D093, 0, 1, F1,       "srai_fetch");
      st(1, 32'h4010D093, 0, 1, DEC,      "srai_decode");
      st(1, 32'h4010D093, 0, 1, EXI_SRAI, "srai_execi");
      st(1, 32'h4010D093, 0, 1, AWB,      "srai_aluwb");

      // addi x1,x0,-1024: instr[30]=1 must not turn add into sub
      st(1, 32'hC0000093, 0, 1, F1,       "addi_fetch");
      st(1, 32'hC0000093, 0, 1, DEC,      "addi_decode");
      st(1, 32'hC0000093, 0, 1, EXI_ADDI, "addi_execi");
      st(1, 32'hC0000093, 0, 1, AWB,      "addi_aluwb");

      // lw with three wait states in MEMREAD
      st(1, 32'h0000A183, 0, 1, F1,    "lw_fetch");
      st(1, 32'h0000A183, 0, 1, DEC,   "lw_decode");
      st(1, 32'h0000A183, 0, 1, MA_LW, "lw_memadr");
      st(1, 32'h0000A183, 0, 0, MRD,   "lw_memread_w1");
      st(1, 32'h0000A183, 0, 0, MRD,   "lw_memread_w2");
      st(1, 32'h0000A183, 0, 0, MRD,   "lw_memread_w3");
      st(1, 32'h0000A183, 0, 1, MRD,   "lw_memread_done");
      st(1, 32'h0000A183, 0, 1, MWB,   "lw_memwb");

      // sw x2,0(x1), zero wait states
      st(1, 32'h0020A023, 0, 1, F1,    "sw_fetch");
      st(1, 32'h0020A023, 0, 1, DEC,   "sw_decode");
      st(1, 32'h0020A023, 0, 1, MA_SW, "sw_memadr");
      st(1, 32'h0020A023, 0, 1, MWR,   "sw_memwrite");

      // beq taken / not taken
      st(1, 32'h00208463, 1, 1, F1,   "beq_t_fetch");
      st(1, 32'h00208463, 1, 1, DEC,  "beq_t_decode");
      st(1, 32'h00208463, 1, 1, BR_T, "beq_t_branch");
      st(1, 32'h00208463, 0, 1, F1,   "beq_n_fetch");
      st(1, 32'h00208463, 0, 1, DEC,  "beq_n_decode");
      st(1, 32'h00208463, 0, 1, BR_N, "beq_n_branch");
      // bne inverse
      st(1, 32'h00209463, 0, 1, F1,   "bne_t_fetch");
      st(1, 32'h00209463, 0, 1, DEC,  "bne_t_decode");
      st(1, 32'h00209463, 0, 1, BR_T, "bne_t_branch");
      st(1, 32'h00209463, 1, 1, F1,   "bne_n_fetch");
      st(1, 32'h00209463, 1, 1, DEC,  "bne_n_decode");
      st(1, 32'h00209463, 1, 1, BR_N, "bne_n_branch");
      // blt: never taken by this controller
      st(1, 32'h0020C463, 1, 1, F1,   "blt_fetch");
      st(1, 32'h0020C463, 1, 1, DEC,  "blt_decode");
      st(1, 32'h0020C463, 1, 1, BR_N, "blt_branch");

      // lui x7,0x15
      st(1, 32'h000153B7, 0, 1, F1,   "lui_fetch");
      st(1, 32'h000153B7, 0, 1, DEC,  "lui_decode");
      st(1, 32'h000153B7, 0, 1, LUIV, "lui_lui");
      st(1, 32'h000153B7, 0, 1, AWB,  "lui_aluwb");
      // auipc x5,0
      st(1, 32'h00000297, 0, 1, F1,   "auipc_fetch");
      st(1, 32'h00000297, 0, 1, DEC,  "auipc_decode");
      st(1, 32'h00000297, 0, 1, AUIV, "auipc_auipc");
      st(1, 32'h00000297, 0, 1, AWB,  "auipc_aluwb");
      // jal x1,8
      st(1, 32'h008000EF, 0, 1, F1,   "jal_fetch");
      st(1, 32'h008000EF, 0, 1, DEC,  "jal_decode");
      st(1, 32'h008000EF, 0, 1, JALV, "jal_jal");
      st(1, 32'h008000EF, 0, 1, AWB,  "jal_aluwb");
      // jalr x1,0(x1)
      st(1, 32'h000080E7, 0, 1, F1,    "jalr_fetch");
      st(1, 32'h000080E7, 0, 1, DEC,   "jalr_decode");
      st(1, 32'h000080E7, 0, 1, JALRV, "jalr_jalr");
      st(1, 32'h000080E7, 0, 1, AWB,   "jalr_aluwb");

      // Unsupported opcode: HALT, illegal sticks even with mem_ready high
      st(1, 32'h0000007F, 0, 1, F1,  "ill_fetch");
      st(1, 32'h0000007F, 0, 1, DEC, "ill_decode");
      st(1, 32'h0000007F, 0, 1, HLT, "ill_halt1");
      st(1, 32'h002081B3, 1, 1, HLT, "ill_halt2");
      st(1, 32'h002081B3, 0, 1, HLT, "ill_halt3");
      // Reset clears illegal immediately
      st(0, 32'h0000A183, 0, 1, RST, "ill_reset");
      st(1, 32'h0000A183, 0, 1, F1,  "post_ill_fetch");

      // lw, reset pulse asynchronously mid-MEMREAD
      st(1, 32'h0000A183, 0, 1, DEC,   "lwr_decode");
      st(1, 32'h0000A183, 0, 1, MA_LW, "lwr_memadr");
      st(1, 32'h0000A183, 0, 0, MRD,   "lwr_memread_w1");
      st(0, 32'h0000A183, 0, 0, RST,   "lwr_reset_mid");
      st(1, 32'h0000A183, 0, 0, FW,    "lwr_refetch_wait");
      st(1, 32'h0000A183, 0, 1, F1,    "lwr_refetch");
      st(1, 32'h0000A183, 0, 1, DEC,   "lwr_decode2");

      // Drain the scoreboard, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
